// File: rtl/weight_bank_loader.sv
// Double-buffered weight matrix loader: packs BUS_WIDTH stores into a shadow matrix and commits atomically.
// Optional macro WEIGHT_READBACK_EN adds a combinational word readback port of the active matrix.
module weight_bank_loader #(
    parameter int MP_BITWIDTH = 8,
    parameter int WEIGHT_SIZE = 4,
    parameter int BUS_WIDTH   = 32,
    localparam int MAT_W  = MP_BITWIDTH * WEIGHT_SIZE * WEIGHT_SIZE,
    localparam int NWORDS = MAT_W / BUS_WIDTH,
    localparam int CNT_W  = $clog2(NWORDS + 1),
    localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 wr_valid_i,
    output logic                 wr_ready_o,
    input  logic [BUS_WIDTH-1:0] wr_data_i,
    input  logic                 hold_i,
    input  logic                 clear_i,
    output logic [MAT_W-1:0]     weight_matrix_o,
    output logic                 weights_valid_o,
    output logic                 commit_o,
    output logic [CNT_W-1:0]     word_cnt_o
`ifdef WEIGHT_READBACK_EN
    ,
    input  logic [IDX_W-1:0]     rd_idx_i,
    output logic [BUS_WIDTH-1:0] rd_data_o
`endif
);

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_PEND = 1'b1
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [CNT_W-1:0]   word_cnt_r;
    logic [CNT_W-1:0]   cnt_nxt_s;
    logic [MAT_W-1:0]   shadow_r;
    logic [MAT_W-1:0]   shadow_nxt_s;
    logic [MAT_W-1:0]   fill_matrix_s;
    logic [MAT_W-1:0]   matrix_r;
    logic               valid_r;
    logic               commit_r;
    logic               store_s;
    logic               commit_fill_s;
    logic               commit_pend_s;

    // Next-state and transfer decode; clear_i outranks everything else
    always_comb begin
        state_nxt_s   = state_r;
        cnt_nxt_s     = word_cnt_r;
        store_s       = 1'b0;
        commit_fill_s = 1'b0;
        commit_pend_s = 1'b0;
        if (clear_i) begin
            state_nxt_s = ST_FILL;
            cnt_nxt_s   = {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_FILL: begin
                    if (wr_valid_i) begin
                        if (word_cnt_r == CNT_W'(NWORDS - 1)) begin
                            if (hold_i) begin
                                store_s     = 1'b1;
                                cnt_nxt_s   = CNT_W'(NWORDS);
                                state_nxt_s = ST_PEND;
                            end else begin
                                commit_fill_s = 1'b1;
                                cnt_nxt_s     = {CNT_W{1'b0}};
                            end
                        end else begin
                            store_s   = 1'b1;
                            cnt_nxt_s = word_cnt_r + CNT_W'(1);
                        end
                    end else begin
                        cnt_nxt_s = word_cnt_r;
                    end
                end
                ST_PEND: begin
                    if (!hold_i) begin
                        commit_pend_s = 1'b1;
                        cnt_nxt_s     = {CNT_W{1'b0}};
                        state_nxt_s   = ST_FILL;
                    end else begin
                        state_nxt_s = ST_PEND;
                    end
                end
                default: begin
                    state_nxt_s = ST_FILL;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // Shadow word insertion; word k lands in the k-th slice counted from the MSB
    always_comb begin
        shadow_nxt_s = shadow_r;
        if (clear_i) begin
            shadow_nxt_s = {MAT_W{1'b0}};
        end else begin
            for (int k = 0; k < NWORDS; k++) begin
                shadow_nxt_s[MAT_W-1-k*BUS_WIDTH -: BUS_WIDTH] =
                    (store_s && (word_cnt_r == CNT_W'(k))) ? wr_data_i
                                                            : shadow_r[MAT_W-1-k*BUS_WIDTH -: BUS_WIDTH];
            end
        end
    end

    // Zero-bubble commit: the last word bypasses the shadow straight into the active matrix
    always_comb begin
        fill_matrix_s                  = shadow_r;
        fill_matrix_s[BUS_WIDTH-1:0]   = wr_data_i;
    end

    // State, shadow and active-matrix registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r    <= ST_FILL;
            word_cnt_r <= {CNT_W{1'b0}};
            shadow_r   <= {MAT_W{1'b0}};
            matrix_r   <= {MAT_W{1'b0}};
            valid_r    <= 1'b0;
            commit_r   <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            word_cnt_r <= cnt_nxt_s;
            shadow_r   <= shadow_nxt_s;
            commit_r   <= commit_fill_s | commit_pend_s;
            valid_r    <= valid_r | commit_fill_s | commit_pend_s;
            if (commit_fill_s) begin
                matrix_r <= fill_matrix_s;
            end else if (commit_pend_s) begin
                matrix_r <= shadow_r;
            end else begin
                matrix_r <= matrix_r;
            end
        end
    end

    assign wr_ready_o      = (state_r == ST_FILL) & ~clear_i;
    assign weight_matrix_o = matrix_r;
    assign weights_valid_o = valid_r;
    assign commit_o        = commit_r;
    assign word_cnt_o      = word_cnt_r;

`ifdef WEIGHT_READBACK_EN
    logic [BUS_WIDTH-1:0] rd_words_s [NWORDS];

    // Split the active matrix into words using the same MSB-first packing as the writer
    always_comb begin
        for (int k = 0; k < NWORDS; k++) begin
            rd_words_s[k] = matrix_r[MAT_W-1-k*BUS_WIDTH -: BUS_WIDTH];
        end
    end

    assign rd_data_o = rd_words_s[rd_idx_i];
`endif

endmodule

// File: tb/tb_weight_bank_loader.sv
// Self-checking bench for weight_bank_loader: directed scenarios plus randomized traffic against a queue model.
module tb_weight_bank_loader;

    localparam int NW = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         wr_valid_i = 1'b0;
    logic         wr_ready_o;
    logic [31:0]  wr_data_i = 32'h0;
    logic         hold_i = 1'b0;
    logic         clear_i = 1'b0;
    logic [127:0] weight_matrix_o;
    logic         weights_valid_o;
    logic         commit_o;
    logic [2:0]   word_cnt_o;
`ifdef WEIGHT_READBACK_EN
    logic [1:0]   rd_idx_i = 2'd0;
    logic [31:0]  rd_data_o;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state
    logic [31:0]  m_q[$];
    logic         m_pend = 1'b0;
    logic [127:0] m_active = 128'h0;
    logic         m_valid = 1'b0;
    logic         m_commit = 1'b0;

    weight_bank_loader dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .wr_valid_i     (wr_valid_i),
        .wr_ready_o     (wr_ready_o),
        .wr_data_i      (wr_data_i),
        .hold_i         (hold_i),
        .clear_i        (clear_i),
        .weight_matrix_o(weight_matrix_o),
        .weights_valid_o(weights_valid_o),
        .commit_o       (commit_o),
        .word_cnt_o     (word_cnt_o)
`ifdef WEIGHT_READBACK_EN
        ,
        .rd_idx_i       (rd_idx_i),
        .rd_data_o      (rd_data_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [127:0] pack_words();
        logic [127:0] m = 128'h0;
        for (int k = 0; k < NW; k++) m[127-32*k -: 32] = m_q[k];
        return m;
    endfunction

    // Reference model: a word list that becomes the active matrix once NW words are held and hold is low
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_pend   = 1'b0;
            m_active = 128'h0;
            m_valid  = 1'b0;
            m_commit = 1'b0;
        end else begin
            m_commit = 1'b0;
            if (clear_i) begin
                m_q.delete();
                m_pend = 1'b0;
            end else if (m_pend) begin
                if (!hold_i) begin
                    m_active = pack_words();
                    m_q.delete();
                    m_pend   = 1'b0;
                    m_commit = 1'b1;
                    m_valid  = 1'b1;
                end
            end else if (wr_valid_i) begin
                m_q.push_back(wr_data_i);
                if (m_q.size() == NW) begin
                    if (hold_i) begin
                        m_pend = 1'b1;
                    end else begin
                        m_active = pack_words();
                        m_q.delete();
                        m_commit = 1'b1;
                        m_valid  = 1'b1;
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the model, mid-cycle while inputs are stable
    always @(negedge clk) begin
        chk("ready",  wr_ready_o,      (!m_pend && !clear_i));
        chk("matrix", weight_matrix_o, m_active);
        chk("valid",  weights_valid_o, m_valid);
        chk("commit", commit_o,        m_commit);
        chk("cnt",    word_cnt_o,      m_q.size());
`ifdef WEIGHT_READBACK_EN
        chk("rdback", rd_data_o,       m_active[127-32*rd_idx_i -: 32]);
`endif
    end

    task automatic drive(input logic v, input logic [31:0] d, input logic h, input logic c);
        @(posedge clk);
        #2;
        wr_valid_i = v;
        wr_data_i  = d;
        hold_i     = h;
        clear_i    = c;
    endtask

    localparam logic [127:0] MAT_T2 = 128'h0102030405060708090A0B0C0D0E0F10;
    localparam logic [127:0] MAT_A  = 128'hA0A0A0A0A1A1A1A1A2A2A2A2A3A3A3A3;
    localparam logic [127:0] MAT_D  = 128'hD0D0D0D0D1D1D1D1D2D2D2D2D3D3D3D3;

    initial begin
        logic [31:0] w2 [4];
        w2[0] = 32'h01020304; w2[1] = 32'h05060708; w2[2] = 32'h090A0B0C; w2[3] = 32'h0D0E0F10;

        // Reset values
        #12;
        chk("t1_matrix", weight_matrix_o, 128'h0);
        chk("t1_valid",  weights_valid_o, 1'b0);
        chk("t1_ready",  wr_ready_o,      1'b1);
        chk("t1_cnt",    word_cnt_o,      3'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Back-to-back fill with zero-bubble commit
        for (int i = 0; i < 4; i++) drive(1'b1, w2[i], 1'b0, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        chk("t2_matrix", weight_matrix_o, MAT_T2);
        chk("t2_commit", commit_o,        1'b1);
        chk("t2_valid",  weights_valid_o, 1'b1);
`ifdef WEIGHT_READBACK_EN
        rd_idx_i = 2'd2;
        #1;
        chk("t6_rdback", rd_data_o, 32'h090A0B0C);
`endif
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        chk("t2_commit_drop", commit_o, 1'b0);

        // Held commit; a following word stalls
        for (int i = 0; i < 4; i++) drive(1'b1, {4{8'hA0 + 8'(i)}}, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'hB0B0B0B0, 1'b1, 1'b0);
            #1;
            chk("t3_ready",  wr_ready_o,      1'b0);
            chk("t3_matrix", weight_matrix_o, MAT_T2);
            chk("t3_cnt",    word_cnt_o,      3'd4);
        end
        drive(1'b1, 32'hB0B0B0B0, 1'b0, 1'b0);
        drive(1'b1, 32'hB0B0B0B0, 1'b0, 1'b0);
        #1;
        chk("t3_matrix_commit", weight_matrix_o, MAT_A);
        chk("t3_commit",        commit_o,        1'b1);
        chk("t3_cnt0",          word_cnt_o,      3'd0);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        chk("t3_stalled_taken", word_cnt_o, 3'd1);

        // Clear mid-fill with a coincident valid word
        drive(1'b1, 32'hC0C0C0C0, 1'b0, 1'b0);
        drive(1'b1, 32'hC1C1C1C1, 1'b0, 1'b0);
        drive(1'b1, 32'hC2C2C2C2, 1'b0, 1'b1);
        #1;
        chk("t4_ready", wr_ready_o, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        chk("t4_cnt",    word_cnt_o,      3'd0);
        chk("t4_matrix", weight_matrix_o, MAT_A);
        for (int i = 0; i < 4; i++) drive(1'b1, {4{8'hD0 + 8'(i)}}, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        chk("t4_matrix_new", weight_matrix_o, MAT_D);

        // Asynchronous reset mid-fill
        for (int i = 0; i < 3; i++) drive(1'b1, $urandom, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        chk("t5_cnt_pre", word_cnt_o, 3'd3);
        #1 rst_n = 1'b0;
        #1;
        chk("t5_matrix", weight_matrix_o, 128'h0);
        chk("t5_valid",  weights_valid_o, 1'b0);
        chk("t5_cnt",    word_cnt_o,      3'd0);
        chk("t5_ready",  wr_ready_o,      1'b1);
        chk("t5_commit", commit_o,        1'b0);
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            drive(($urandom_range(99) < 70), $urandom, ($urandom_range(99) < 30),
                  ($urandom_range(99) < 4));
`ifdef WEIGHT_READBACK_EN
            rd_idx_i = 2'($urandom_range(3));
`endif
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        @(posedge clk);
        #3;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
